// File: rtl/seq_pkg.sv
// Shared definitions for the datapath sequencer: state encoding and
// program-memory geometry.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

    localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;
    localparam int          PROG_DEPTH       = 16;
    localparam int          ADDR_W           = 4;
    localparam int          WORD_W           = 16;
    localparam int          LEN_W            = 5;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Load, run-control and status signals between the host side and the
// datapath sequencer.
interface datapath_sequencer_if;
    import seq_pkg::*;

    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [WORD_W-1:0] load_data;
    logic [LEN_W-1:0]  prog_len;
    logic              start;
    logic              single_step;
    logic              step;
    logic              abort;
    logic              halt_on_z;
    logic              z_flag;
    logic [WORD_W-1:0] control_word;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;
    logic              aborted;

    modport master (
        output load_en, load_addr, load_data, prog_len, start, single_step,
               step, abort, halt_on_z, z_flag,
        input  control_word, pc, busy, done, aborted
    );

    modport slave (
        input  load_en, load_addr, load_data, prog_len, start, single_step,
               step, abort, halt_on_z, z_flag,
        output control_word, pc, busy, done, aborted
    );

endinterface

// File: rtl/seq_prog_mem.sv
// Program store: synchronous write, combinational read, never cleared by reset
// so a loaded program survives a sequencer reset.
module seq_prog_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/datapath_sequencer.sv
// Issues stored control words to the datapath, free-running or one per step pulse.
// state  | meaning
// IDLE   | NOP driven, program loadable, waiting for start
// RUN    | one word per cycle from mem[pc]
// STEP   | one word on the cycle after each step pulse, NOP otherwise
// DONE   | single-cycle done pulse, NOP driven
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter logic [15:0] NOP_WORD = NOP_WORD_DEFAULT,
    parameter int          DEPTH    = PROG_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    datapath_sequencer_if.slave bus
);

    seq_state_t        state, state_nx;
    logic [WORD_W-1:0] cw, cw_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [LEN_W-1:0]  len, len_nx;
    logic              hz, hz_nx;
    logic              abt, abt_nx;
    logic [WORD_W-1:0] mem_word;
    logic              mem_we;
    logic              last_word;
    logic              stop_req;

    // Writes only land in IDLE, so a running program can never be altered.
    assign mem_we = (state == S_IDLE) && bus.load_en;

    seq_prog_mem #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_prog_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(bus.load_addr),
        .wdata(bus.load_data),
        .raddr(pc),
        .rdata(mem_word)
    );

    // 5-bit compare so prog_len = 16 finishes at pc 15 and pc wraps to 0.
    assign last_word = (({1'b0, pc} + 5'd1) == len);
    assign stop_req  = bus.abort || (hz && bus.z_flag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cw    <= NOP_WORD;
            pc    <= '0;
            len   <= '0;
            hz    <= 1'b0;
            abt   <= 1'b0;
        end else begin
            state <= state_nx;
            cw    <= cw_nx;
            pc    <= pc_nx;
            len   <= len_nx;
            hz    <= hz_nx;
            abt   <= abt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cw_nx    = NOP_WORD;
        pc_nx    = pc;
        len_nx   = len;
        hz_nx    = hz;
        abt_nx   = abt;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    pc_nx  = '0;
                    len_nx = bus.prog_len;
                    hz_nx  = bus.halt_on_z;
                    abt_nx = 1'b0;
                    if (bus.prog_len == '0)   state_nx = S_DONE;
                    else if (bus.single_step) state_nx = S_STEP;
                    else                      state_nx = S_RUN;
                end
            end
            S_RUN, S_STEP: begin
                if (stop_req) begin
                    state_nx = S_DONE;
                    abt_nx   = 1'b1;
                end else if (state == S_RUN || bus.step) begin
                    cw_nx = mem_word;
                    pc_nx = pc + 4'd1;
                    if (last_word) state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.control_word = cw;
    assign bus.pc           = pc;
    assign bus.busy         = (state == S_RUN) || (state == S_STEP);
    assign bus.done         = (state == S_DONE);
    assign bus.aborted      = abt;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for the datapath sequencer; expected words come from a
// fixed program image defined here.
module tb_datapath_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    datapath_sequencer_if bus();

    datapath_sequencer dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] word_at(input int i);
        if (i == 15) return 16'hF00D;
        return 16'(32'h1111 * (i + 1));
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [15:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = 4'(a);
        bus.load_data = d;
        tick();
        bus.load_en   = 1'b0;
    endtask

    task automatic start_run(input int n, input logic ss, input logic hz);
        bus.prog_len    = 5'(n);
        bus.single_step = ss;
        bus.halt_on_z   = hz;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.prog_len = '0;  bus.start = 1'b0;   bus.single_step = 1'b0;
        bus.step = 1'b0;    bus.abort = 1'b0;   bus.halt_on_z = 1'b0;
        bus.z_flag = 1'b0;

        #2;
        check_eq("rst_cw",      32'(bus.control_word), 32'h0);
        check_eq("rst_pc",      32'(bus.pc),           32'h0);
        check_eq("rst_busy",    32'(bus.busy),         32'h0);
        check_eq("rst_done",    32'(bus.done),         32'h0);
        check_eq("rst_aborted", 32'(bus.aborted),      32'h0);
        tick(); tick();
        reset = 1'b0;

        for (int i = 0; i < 16; i++) load_word(i, word_at(i));

        // free run of four words
        start_run(4, 1'b0, 1'b0);
        check_eq("run4_busy0", 32'(bus.busy), 32'h1);
        check_eq("run4_cw0",   32'(bus.control_word), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("run4_word", 32'(bus.control_word), 32'(word_at(i)));
            check_eq("run4_pc",   32'(bus.pc), 32'(i + 1));
            check_eq("run4_done", 32'(bus.done), (i == 3) ? 32'h1 : 32'h0);
            check_eq("run4_busy", 32'(bus.busy), (i == 3) ? 32'h0 : 32'h1);
        end
        tick();
        check_eq("run4_end_cw",   32'(bus.control_word), 32'h0);
        check_eq("run4_end_done", 32'(bus.done), 32'h0);

        // write and start in the same cycle
        bus.load_en = 1'b1; bus.load_addr = 4'd0; bus.load_data = 16'h1234;
        start_run(1, 1'b0, 1'b0);
        bus.load_en = 1'b0;
        tick();
        check_eq("wr_start_cw",   32'(bus.control_word), 32'h1234);
        check_eq("wr_start_done", 32'(bus.done), 32'h1);
        tick();
        load_word(0, word_at(0));

        // empty program
        start_run(0, 1'b0, 1'b0);
        check_eq("len0_done",    32'(bus.done), 32'h1);
        check_eq("len0_busy",    32'(bus.busy), 32'h0);
        check_eq("len0_cw",      32'(bus.control_word), 32'h0);
        check_eq("len0_aborted", 32'(bus.aborted), 32'h0);
        tick();
        check_eq("len0_done_off", 32'(bus.done), 32'h0);

        // step in IDLE does nothing
        bus.step = 1'b1; tick(); bus.step = 1'b0;
        check_eq("idle_step_cw",   32'(bus.control_word), 32'h0);
        check_eq("idle_step_busy", 32'(bus.busy), 32'h0);

        // single step, two pulses five cycles apart
        start_run(2, 1'b1, 1'b0);
        check_eq("step_busy", 32'(bus.busy), 32'h1);
        tick(); tick();
        check_eq("step_wait_cw", 32'(bus.control_word), 32'h0);
        check_eq("step_wait_pc", 32'(bus.pc), 32'h0);
        bus.step = 1'b1; tick(); bus.step = 1'b0;
        check_eq("step1_cw",   32'(bus.control_word), 32'(word_at(0)));
        check_eq("step1_pc",   32'(bus.pc), 32'h1);
        check_eq("step1_done", 32'(bus.done), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("step_gap_cw",   32'(bus.control_word), 32'h0);
            check_eq("step_gap_busy", 32'(bus.busy), 32'h1);
        end
        bus.step = 1'b1; tick(); bus.step = 1'b0;
        check_eq("step2_cw",   32'(bus.control_word), 32'(word_at(1)));
        check_eq("step2_done", 32'(bus.done), 32'h1);
        tick();
        check_eq("step_end_cw", 32'(bus.control_word), 32'h0);

        // Z halt on the third run cycle
        start_run(8, 1'b0, 1'b1);
        tick();
        tick();
        check_eq("zh_word1", 32'(bus.control_word), 32'(word_at(1)));
        bus.z_flag = 1'b1; tick(); bus.z_flag = 1'b0;
        check_eq("zh_done",    32'(bus.done), 32'h1);
        check_eq("zh_aborted", 32'(bus.aborted), 32'h1);
        check_eq("zh_pc",      32'(bus.pc), 32'h2);
        check_eq("zh_cw",      32'(bus.control_word), 32'h0);
        tick();
        check_eq("zh_aborted_held", 32'(bus.aborted), 32'h1);

        // abort in RUN
        start_run(8, 1'b0, 1'b0);
        check_eq("ab_cleared", 32'(bus.aborted), 32'h0);
        tick();
        check_eq("ab_word0", 32'(bus.control_word), 32'(word_at(0)));
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        check_eq("ab_done",    32'(bus.done), 32'h1);
        check_eq("ab_aborted", 32'(bus.aborted), 32'h1);
        check_eq("ab_cw",      32'(bus.control_word), 32'h0);
        check_eq("ab_pc",      32'(bus.pc), 32'h1);
        tick();

        // abort beats step in STEP
        start_run(3, 1'b1, 1'b0);
        bus.step = 1'b1; bus.abort = 1'b1; tick(); bus.step = 1'b0; bus.abort = 1'b0;
        check_eq("abst_cw",      32'(bus.control_word), 32'h0);
        check_eq("abst_done",    32'(bus.done), 32'h1);
        check_eq("abst_pc",      32'(bus.pc), 32'h0);
        check_eq("abst_aborted", 32'(bus.aborted), 32'h1);
        tick();

        // load during RUN must be dropped
        start_run(4, 1'b0, 1'b0);
        bus.load_en = 1'b1; bus.load_addr = 4'd5; bus.load_data = 16'hBEEF;
        tick();
        bus.load_en = 1'b0;
        tick(); tick(); tick(); tick();
        start_run(6, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("mem5_run_word", 32'(bus.control_word), 32'(word_at(i)));
        end
        tick();

        // reset mid-run
        start_run(8, 1'b0, 1'b0);
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        check_eq("mrst_cw",   32'(bus.control_word), 32'h0);
        check_eq("mrst_pc",   32'(bus.pc), 32'h0);
        check_eq("mrst_busy", 32'(bus.busy), 32'h0);
        check_eq("mrst_done", 32'(bus.done), 32'h0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("mrst_no_done", 32'(bus.done), 32'h0);
        end
        start_run(1, 1'b0, 1'b0);
        tick();
        check_eq("mrst_mem_kept", 32'(bus.control_word), 32'(word_at(0)));
        tick();

        // full sixteen-word run with a stray start
        start_run(16, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                bus.start = 1'b1;
                bus.prog_len = 5'd2;
            end
            tick();
            bus.start = 1'b0;
            check_eq("full_word", 32'(bus.control_word), 32'(word_at(i)));
            check_eq("full_pc",   32'(bus.pc), 32'((i + 1) % 16));
            check_eq("full_done", 32'(bus.done), (i == 15) ? 32'h1 : 32'h0);
        end
        tick();
        check_eq("full_end_cw",   32'(bus.control_word), 32'h0);
        check_eq("full_end_busy", 32'(bus.busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
